// File: rtl/rot_shift_seq.sv
// Multi-cycle shifter/rotator that resolves one log2 stage per clock (ROL/SLL/ROR/SRA).
// Optional macro SHIFT_SKIP_EN: leave SHIFT once no higher shamt bits remain.
module rot_shift_seq #(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {OP_ROL = 2'b00, OP_SLL = 2'b01, OP_ROR = 2'b10, OP_SRA = 2'b11} op_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] stage;
    logic [WIDTH-1:0]   shifted, stage_res;
    logic               accept, last_stage;
    int unsigned        amt;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = data;

    // Single stage: move by 2^stage, only when that shamt bit is set.
    always_comb begin
        amt = 32'd1 << stage;
        shifted = data;
        case (op_t'(op))
            OP_ROL:  shifted = (data << amt) | (data >> (WIDTH - amt));
            OP_SLL:  shifted = data << amt;
            OP_ROR:  shifted = (data >> amt) | (data << (WIDTH - amt));
            OP_SRA:  shifted = $signed(data) >>> amt;
            default: shifted = data;
        endcase
        stage_res = shamt[stage] ? shifted : data;
    end

`ifdef SHIFT_SKIP_EN
    // Remaining higher shamt bits all zero means later stages are pass-through.
    assign last_stage = (stage == SHAMT_W'(SHAMT_W - 1)) ||
                        ((shamt >> (int'(stage) + 1)) == '0);
`else
    assign last_stage = (stage == SHAMT_W'(SHAMT_W - 1));
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_stage) state_nxt = DONE;
            DONE: begin
                if (accept)         state_nxt = SHIFT;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            shamt <= '0;
            op    <= '0;
            stage <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data  <= in_data;
                shamt <= in_shamt;
                op    <= in_op;
                stage <= '0;
            end else if (state == SHIFT) begin
                data  <= stage_res;
                stage <= stage + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rot_shift_seq.sv
// Self-checking bench for rot_shift_seq: directed cases plus random ops against a behavioural model.
module tb_rot_shift_seq;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
    logic [15:0] in_data = 0, out_data;
    logic [3:0]  in_shamt = 0;
    logic [1:0]  in_op = 0;
    int          errors = 0, checks = 0;

    rot_shift_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_model(input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        logic [31:0]        dd;
        logic signed [15:0] sd;
        dd = {d, d};
        sd = d;
        case (o)
            2'b00:   begin dd = dd << s; return dd[31:16]; end
            2'b01:   return d << s;
            2'b10:   begin dd = dd >> s; return dd[15:0]; end
            default: return sd >>> s;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] s);
        int l;
`ifdef SHIFT_SKIP_EN
        l = 1;
        for (int i = 0; i < 4; i++) if (s[i]) l = i + 1;
`else
        l = 4;
`endif
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at the negedge; it is accepted on the next posedge.
    task automatic present(input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        in_valid = 1; in_data = d; in_shamt = s; in_op = o;
        @(posedge clk); #1;
        in_valid = 0; in_data = 16'($urandom); in_shamt = 4'($urandom); in_op = 2'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        int lat;
        @(negedge clk);
        out_ready = 1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        present(d, s, o);
        wait_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(s)));
        chk({tag, "_data"}, 32'(out_data), 32'(ref_model(d, s, o)));
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    initial begin
        int          lat, lat_b;
        logic [15:0] hold_d, rd, ra, rb;
        logic [3:0]  rs;
        logic [1:0]  ro;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk); rst_n = 1;

        run_op("rol_1234_4", 16'h1234, 4'd4, 2'b00);
        run_op("sra_8001_1", 16'h8001, 4'd1, 2'b11);
        run_op("sll_ffff_15", 16'hFFFF, 4'd15, 2'b01);
        run_op("ror_0001_1", 16'h0001, 4'd1, 2'b10);
        run_op("shamt0_rol", 16'hBEEF, 4'd0, 2'b00);
        run_op("shamt0_sra", 16'h8F00, 4'd0, 2'b11);
        run_op("sra_8000_15", 16'h8000, 4'd15, 2'b11);
        run_op("ror_1234_9", 16'h1234, 4'd9, 2'b10);
        run_op("sll_00ff_2", 16'h00FF, 4'd2, 2'b01);

        // Backpressure: result must stay put while out_ready is low.
        @(negedge clk); out_ready = 0;
        present(16'hA5C3, 4'd7, 2'b00);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'(exp_lat(4'd7)));
        hold_d = ref_model(16'hA5C3, 4'd7, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {15'd0, out_valid, in_ready, out_data}, {15'd0, 1'b1, 1'b0, hold_d});
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release", {30'd0, out_valid, busy}, 32'd0);

        // Back-to-back: new request accepted on the same edge that drains the old result.
        @(negedge clk);
        ra = ref_model(16'h1357, 4'd5, 2'b10);
        rb = ref_model(16'hC001, 4'd3, 2'b11);
        present(16'h1357, 4'd5, 2'b10);
        wait_valid(lat);
        chk("b2b_a_data", 32'(out_data), 32'(ra));
        in_valid = 1; in_data = 16'hC001; in_shamt = 4'd3; in_op = 2'b11;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("b2b_no_dup", {30'd0, out_valid, busy}, 32'd1);
        wait_valid(lat_b);
        chk("b2b_spacing", 32'(lat_b), 32'(exp_lat(4'd3)));
        chk("b2b_b_data", 32'(out_data), 32'(rb));
        @(posedge clk); #1;
        chk("b2b_idle", 32'(out_valid), 32'd0);

        // Reset mid-SHIFT discards the operation.
        @(negedge clk);
        present(16'hFFFF, 4'd15, 2'b01);
        @(posedge clk); #1;
        rst_n = 0; #1;
        chk("midrst_state", {29'd0, out_valid, busy, in_ready}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_hold", {29'd0, out_valid, busy, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1;
        run_op("after_rst", 16'h0F0F, 4'd6, 2'b00);

        for (int n = 0; n < 24; n++) begin
            rd = 16'($urandom);
            rs = 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            run_op("rand", rd, rs, ro);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
